// File: rtl/inst_bank_scheduler.sv
// Owns the single instruction-RAM port: the loader writes programs through it, and runs stream reads out to fetch through a FWFT skid FIFO.
// Define IBANK_CHECKSUM_EN to build the XOR checksum of the most recent load.
module inst_bank_scheduler #(
    parameter int NUM_INSTRUCTIONS  = 256,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int ADDR_WIDTH        = $clog2(NUM_INSTRUCTIONS),
    parameter int DATA_WIDTH        = INSTRUCTION_WIDTH,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we,
    output logic                  ram_en,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic [DATA_WIDTH-1:0] load_checksum
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_PC = '1;
    localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DRAIN} state_t;

    state_t state, state_next;

    logic                  loaded;
    logic                  wrapped;
    logic                  run_epoch;
    logic [ADDR_WIDTH-1:0] pc;

    logic                  vld_p1, vld_p2;
    logic                  epoch_p1, epoch_p2;
    logic [ADDR_WIDTH-1:0] pc_p1, pc_p2;

    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      fifo_count;

    logic                  load_accept;
    logic                  run_start;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic                  flush;
    logic                  ret_live;
    logic [CNT_W:0]        outstanding;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credits cover every word that will need a FIFO slot: queued words plus reads in flight.
    assign outstanding = {1'b0, fifo_count} + {{CNT_W{1'b0}}, vld_p1} + {{CNT_W{1'b0}}, vld_p2};
    assign ret_live    = vld_p2 && (epoch_p2 == run_epoch);
    assign inst_valid  = (fifo_count != '0);
    assign pop         = inst_valid && inst_ready;
    assign inst        = inst_valid ? fifo_data[rd_ptr] : '0;
    assign inst_pc     = inst_valid ? fifo_pc[rd_ptr] : '0;
    assign busy        = (state == ST_RUN) || (state == ST_DRAIN);

    always_comb begin
        state_next  = state;
        load_ready  = 1'b0;
        load_accept = 1'b0;
        run_start   = 1'b0;
        issue       = 1'b0;
        push        = 1'b0;
        flush       = 1'b0;
        done        = 1'b0;
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = pc;
        ram_din     = '0;

        case (state)
            ST_IDLE, ST_LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    load_accept = 1'b1;
                    ram_en      = 1'b1;
                    ram_we      = 1'b1;
                    ram_addr    = load_addr;
                    ram_din     = load_data;
                    state_next  = load_last ? ST_IDLE : ST_LOAD;
                end else if (state == ST_IDLE && start && loaded) begin
                    run_start  = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    flush      = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    if (!wrapped && outstanding < CREDIT_MAX) begin
                        issue  = 1'b1;
                        ram_en = 1'b1;
                    end
                    if (ret_live) begin
                        push = (ram_dout != '0);
                        if (ram_dout == '0 || pc_p2 == LAST_PC) state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    flush      = 1'b1;
                    state_next = ST_IDLE;
                end else if (fifo_count == '0 && !vld_p1 && !vld_p2) begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            loaded     <= 1'b0;
            wrapped    <= 1'b0;
            run_epoch  <= 1'b0;
            pc         <= '0;
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            state <= state_next;
            if (load_accept) loaded <= load_last;

            if (run_start) begin
                pc        <= '0;
                wrapped   <= 1'b0;
                run_epoch <= ~run_epoch;
            end else if (flush) begin
                run_epoch <= ~run_epoch;
            end else if (issue) begin
                pc <= pc + 1'b1;
                if (pc == LAST_PC) wrapped <= 1'b1;
            end

            // p1: read issued last cycle; p2: its word is on ram_dout now
            vld_p1 <= issue;
            vld_p2 <= vld_p1;

            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
                case ({push, pop})
                    2'b10:   fifo_count <= fifo_count + 1'b1;
                    2'b01:   fifo_count <= fifo_count - 1'b1;
                    default: fifo_count <= fifo_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        pc_p1    <= pc;
        epoch_p1 <= run_epoch;
        pc_p2    <= pc_p1;
        epoch_p2 <= epoch_p1;
        if (push) begin
            fifo_data[wr_ptr] <= ram_dout;
            fifo_pc[wr_ptr]   <= pc_p2;
        end
    end

`ifdef IBANK_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum;

    // The first beat accepted from IDLE opens a new load and restarts the accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= '0;
        end else if (load_accept) begin
            checksum <= (state == ST_IDLE) ? load_data : (checksum ^ load_data);
        end
    end

    assign load_checksum = checksum;
`else
    assign load_checksum = '0;
`endif

endmodule

// File: tb/tb_inst_bank_scheduler.sv
// Randomized bench for inst_bank_scheduler: RAM model with 2-cycle reads, scoreboard fed from a program-level model.
module tb_inst_bank_scheduler;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int FD = 4;
    localparam int NW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_valid;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          load_last;
    logic          load_ready;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic          ram_en;
    logic [DW-1:0] ram_dout;
    logic          inst_valid;
    logic          inst_ready;
    logic [DW-1:0] inst;
    logic [AW-1:0] inst_pc;
    logic [DW-1:0] load_checksum;

    always #5 clk = ~clk;

    inst_bank_scheduler #(
        .NUM_INSTRUCTIONS (NW),
        .INSTRUCTION_WIDTH(DW),
        .ADDR_WIDTH       (AW),
        .DATA_WIDTH       (DW),
        .FIFO_DEPTH       (FD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .load_last    (load_last),
        .load_ready   (load_ready),
        .start        (start),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_we       (ram_we),
        .ram_en       (ram_en),
        .ram_dout     (ram_dout),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .load_checksum(load_checksum)
    );

    // Environment RAM: write on en&we, read data appears two cycles after en.
    logic [DW-1:0] ram [NW];
    logic [DW-1:0] ram_rd_p1;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NW; i++) ram[i] <= '0;
        end else if (ram_en && ram_we) begin
            ram[ram_addr] <= ram_din;
        end
        if (ram_en && !ram_we) ram_rd_p1 <= ram[ram_addr];
        ram_dout <= ram_rd_p1;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: bank contents as the loader left them, and the stream a run must produce.
    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] data;
    } item_t;

    logic [DW-1:0] ref_mem [NW];
    logic [DW-1:0] prog    [NW];
    item_t         exp_q [$];

    function automatic void build_expected();
        exp_q.delete();
        for (int p = 0; p < NW; p++) begin
            if (ref_mem[p] == '0) break;
            exp_q.push_back('{pc: AW'(p), data: ref_mem[p]});
        end
    endfunction

    int            pops = 0;
    int            reads = 0;
    int            addr0_reads = 0;
    int            done_cnt = 0;
    int            first_valid_cyc = -1;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_inst;
    logic [AW-1:0] prev_pc;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall && inst_valid) begin
                check("hold_inst", 32'(inst), 32'(prev_inst));
                check("hold_pc", 32'(inst_pc), 32'(prev_pc));
            end
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_inst", 32'(inst), 32'hFFFF_FFFF);
                end else begin
                    item_t e;
                    e = exp_q.pop_front();
                    check("inst", 32'(inst), 32'(e.data));
                    check("inst_pc", 32'(inst_pc), 32'(e.pc));
                end
                pops++;
            end
            if (done) begin
                done_cnt++;
                check("done_before_stream_end", 32'(exp_q.size()), 0);
            end
            if (ram_en && !ram_we) begin
                reads++;
                if (ram_addr == '0) addr0_reads++;
            end
            prev_stall = inst_valid && !inst_ready;
            prev_inst  = inst;
            prev_pc    = inst_pc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        load_valid = 1'b0; load_addr = '0; load_data = '0; load_last = 1'b0;
        start = 1'b0; abort = 1'b0; inst_ready = 1'b0;
        for (int i = 0; i < NW; i++) ref_mem[i] = '0;
        exp_q.delete();
        repeat (3) tick();
        rst = 1'b0;
        sample();
        check("rst_load_ready", 32'(load_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_inst_valid", 32'(inst_valid), 0);
        check("rst_ram_en", 32'(ram_en), 0);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_inst", 32'(inst), 0);
        check("rst_inst_pc", 32'(inst_pc), 0);
        check("rst_checksum", 32'(load_checksum), 0);
        tick();
    endtask

    task automatic load_words(input int n);
        logic [DW-1:0] xs;
        xs = '0;
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_addr  = AW'(i);
            load_data  = prog[i];
            load_last  = (i == n - 1);
            ref_mem[i] = prog[i];
            xs         = xs ^ prog[i];
            sample();
            check("load_ready", 32'(load_ready), 1);
            check("load_write", 32'(ram_we && ram_en), 1);
            check("load_addr", 32'(ram_addr), 32'(i));
            check("load_din", 32'(ram_din), 32'(prog[i]));
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        sample();
`ifdef IBANK_CHECKSUM_EN
        check("checksum", 32'(load_checksum), 32'(xs));
`else
        check("checksum", 32'(load_checksum), 32'(xs & 8'h00));
`endif
        tick();
    endtask

    task automatic run_prog(input int ready_pct, input int stall);
        int d0, r0, t0;
        bit got;
        build_expected();
        d0 = done_cnt;
        r0 = reads;
        first_valid_cyc = -1;
        start = 1'b1;
        inst_ready = 1'b0;
        t0 = cyc;
        tick();
        start = 1'b0;
        for (int s = 0; s < stall; s++) begin
            inst_ready = 1'b0;
            if (s == stall - 1) begin
                sample();
                check("bp_reads_le_depth", 32'((reads - r0) <= FD), 1);
                if (exp_q.size() > 0) begin
                    check("bp_valid", 32'(inst_valid), 1);
                    check("bp_inst", 32'(inst), 32'(exp_q[0].data));
                    check("bp_pc", 32'(inst_pc), 32'(exp_q[0].pc));
                end
            end
            tick();
        end
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            inst_ready = (int'($urandom_range(0, 99)) < ready_pct);
            sample();
            if (done_cnt != d0) got = 1'b1;
            else tick();
        end
        check("done_seen", 32'(got), 1);
        if (ready_pct == 100 && stall == 0) check("first_valid_latency", 32'(first_valid_cyc - t0), 4);
        tick();
        inst_ready = 1'b0;
        sample();
        check("busy_after_done", 32'(busy), 0);
        check("inst_valid_after_done", 32'(inst_valid), 0);
        check("done_once", 32'(done_cnt - d0), 1);
        check("stream_complete", 32'(exp_q.size()), 0);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, a0, n;
        bit seen, quiet;

        do_reset();

        // start with nothing loaded is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        sample();
        check("start_unloaded_busy", 32'(busy), 0);
        tick();

        // start colliding with a load beat: the beat is written, no run
        load_valid = 1'b1; load_addr = '0; load_data = 8'h5C; load_last = 1'b1; start = 1'b1;
        ref_mem[0] = 8'h5C;
        sample();
        check("conflict_we", 32'(ram_we), 1);
        check("conflict_din", 32'(ram_din), 32'h5C);
        tick();
        load_valid = 1'b0; load_last = 1'b0; start = 1'b0;
        sample();
        check("conflict_no_run", 32'(busy), 0);
        tick();
        run_prog(100, 0);

        prog[0] = 8'hA5; prog[1] = 8'h0F; prog[2] = 8'hF0;
        load_words(3);
        run_prog(60, 0);

        prog[0] = 8'h11; prog[1] = 8'h22; prog[2] = 8'h33; prog[3] = 8'h00;
        load_words(4);
        run_prog(100, 0);
        run_prog(100, 10);

        // abort two cycles after the first instruction appears
        for (int i = 0; i < 6; i++) prog[i] = DW'($urandom_range(1, 255));
        prog[6] = 8'h00;
        load_words(7);
        build_expected();
        d0 = done_cnt;
        start = 1'b1;
        inst_ready = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            sample();
            if (inst_valid) seen = 1'b1;
            else tick();
        end
        check("abort_saw_valid", 32'(seen), 1);
        tick();
        tick();
        abort = 1'b1;
        inst_ready = 1'b0;
        sample();
        tick();
        abort = 1'b0;
        sample();
        check("abort_idle", 32'(busy), 0);
        check("abort_valid_low", 32'(inst_valid), 0);
        quiet = 1'b1;
        repeat (4) begin
            tick();
            sample();
            if (inst_valid || busy) quiet = 1'b0;
        end
        check("abort_quiet", 32'(quiet), 1);
        check("abort_no_done", 32'(done_cnt - d0), 0);
        exp_q.delete();
        tick();
        run_prog(80, 0);

        // every word nonzero: the run stops at the top address without re-reading 0
        for (int i = 0; i < NW; i++) prog[i] = DW'($urandom_range(1, 255));
        load_words(NW);
        a0 = addr0_reads;
        run_prog(70, 0);
        check("wrap_addr0_once", 32'(addr0_reads - a0), 1);

        for (int it = 0; it < 10; it++) begin
            n = int'($urandom_range(2, NW));
            for (int i = 0; i < n; i++) prog[i] = DW'($urandom_range(1, 255));
            if ($urandom_range(0, 1) == 1) prog[n-1] = 8'h00;
            load_words(n);
            run_prog(int'($urandom_range(30, 100)),
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(4, 8)) : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
